// File: rtl/op_exec_unit_if.sv
// Bus between the issue logic and the execute unit: the issue request with its
// operands, and the registered completion/result signals coming back.
interface op_exec_unit_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 12
);
  logic              op_en;
  logic [3:0]        opcode;
  logic [PC_W-1:0]   prog_ctr;
  logic [DATA_W-1:0] r0;
  logic [DATA_W-1:0] r1;
  logic [DATA_W-1:0] r2;
  logic              r0_valid;
  logic              r1_valid;
  logic              r2_valid;
  logic [DATA_W-1:0] result;
  logic              carry;
  logic              zero;
  logic              done;
  logic              busy;
  logic              operand_err;

  // Issuer side: drives the request, observes the completion
  modport master (
    output op_en, opcode, prog_ctr, r0, r1, r2, r0_valid, r1_valid, r2_valid,
    input  result, carry, zero, done, busy, operand_err
  );

  // Execute-unit side
  modport slave (
    input  op_en, opcode, prog_ctr, r0, r1, r2, r0_valid, r1_valid, r2_valid,
    output result, carry, zero, done, busy, operand_err
  );
endinterface

// File: rtl/op_exec_unit.sv
// Execute stage: accepts one op per program-counter value, runs single-cycle
// ALU ops in EXEC and MUL/MAC through an iterative shift-add multiplier.
module op_exec_unit #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 12
) (
  input logic           clk,
  input logic           reset,
  op_exec_unit_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, MAC_ADD} state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     last_pc_q, last_pc_d;
  logic [3:0]          opcode_q, opcode_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
  logic [2:0]          vld_q, vld_d;
  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic [2*DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                carry_q, carry_d;
  logic                zero_q, zero_d;
  logic                done_q, done_d;
  logic                oerr_q, oerr_d;

  // Operand slots an opcode needs, as {r2, r1, r0}
  function automatic logic [2:0] req_mask(input logic [3:0] op);
    case (op)
      4'd5:        req_mask = 3'b001;
      4'd9, 4'd10: req_mask = 3'b111;
      default:     req_mask = 3'b011;
    endcase
  endfunction

  // Opcode is defined and every operand it needs was valid
  function automatic logic op_ok(input logic [3:0] op, input logic [2:0] vld);
    op_ok = (op <= 4'd10) && ((vld & req_mask(op)) == req_mask(op));
  endfunction

  logic                accept;
  logic [2:0]          vld_in;
  logic [DATA_W:0]     add_sum;
  logic [DATA_W:0]     sub_diff;
  logic [DATA_W+1:0]   add3_sum;
  logic [2*DATA_W-1:0] shl_w, shr_w;
  logic [2*DATA_W-1:0] mul_step;
  logic [2*DATA_W:0]   mac_sum;

  assign vld_in = {bus.r2_valid, bus.r1_valid, bus.r0_valid};
  assign accept = (state_q == IDLE) && bus.op_en && (bus.prog_ctr != last_pc_q);

  // Datapath terms; shifts use a double-width window so the last bit shifted
  // out lands just outside the result byte (and is 0 for a zero shift)
  assign add_sum  = {1'b0, a_q} + {1'b0, b_q};
  assign sub_diff = {1'b0, a_q} - {1'b0, b_q};
  assign add3_sum = {2'b00, a_q} + {2'b00, b_q} + {2'b00, c_q};
  assign shl_w    = {{DATA_W{1'b0}}, a_q} << b_q[2:0];
  assign shr_w    = {a_q, {DATA_W{1'b0}}} >> b_q[2:0];
  assign mul_step = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign mac_sum  = {1'b0, prod_q} + {{(DATA_W+1){1'b0}}, c_q};

  // State register and all datapath/output flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_pc_q <= '1;
      opcode_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      vld_q     <= '0;
      prod_q    <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      done_q    <= 1'b0;
      oerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_pc_q <= last_pc_d;
      opcode_q  <= opcode_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      vld_q     <= vld_d;
      prod_q    <= prod_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      done_q    <= done_d;
      oerr_q    <= oerr_d;
    end
  end

  // Next-state, operand capture, execution and completion
  always_comb begin
    state_d   = state_q;
    last_pc_d = last_pc_q;
    opcode_d  = opcode_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    vld_d     = vld_q;
    prod_d    = prod_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    done_d    = 1'b0;
    oerr_d    = oerr_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          last_pc_d = bus.prog_ctr;
          opcode_d  = bus.opcode;
          a_d       = bus.r0;
          b_d       = bus.r1;
          c_d       = bus.r2;
          vld_d     = vld_in;
          prod_d    = '0;
          mcand_d   = {{DATA_W{1'b0}}, bus.r0};
          mplier_d  = bus.r1;
          cnt_d     = '0;
          // Rejected MUL/MAC go through EXEC so errors always report at T+1
          if (op_ok(bus.opcode, vld_in) &&
              (bus.opcode == 4'd8 || bus.opcode == 4'd9))
            state_d = MUL;
          else
            state_d = EXEC;
        end
      end

      EXEC: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!op_ok(opcode_q, vld_q)) begin
          oerr_d = 1'b1;
        end else begin
          oerr_d  = 1'b0;
          carry_d = 1'b0;
          case (opcode_q)
            4'd0: begin
              result_d = add_sum[DATA_W-1:0];
              carry_d  = add_sum[DATA_W];
            end
            4'd1: begin
              result_d = sub_diff[DATA_W-1:0];
              carry_d  = sub_diff[DATA_W];
            end
            4'd2: result_d = a_q & b_q;
            4'd3: result_d = a_q | b_q;
            4'd4: result_d = a_q ^ b_q;
            4'd5: result_d = ~a_q;
            4'd6: begin
              result_d = shl_w[DATA_W-1:0];
              carry_d  = shl_w[DATA_W];
            end
            4'd7: begin
              result_d = shr_w[2*DATA_W-1:DATA_W];
              carry_d  = shr_w[DATA_W-1];
            end
            default: begin
              result_d = add3_sum[DATA_W-1:0];
              carry_d  = |add3_sum[DATA_W+1:DATA_W];
            end
          endcase
          zero_d = (result_d == '0);
        end
      end

      MUL: begin
        prod_d   = mul_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          if (opcode_q == 4'd9) begin
            state_d = MAC_ADD;
          end else begin
            state_d  = IDLE;
            done_d   = 1'b1;
            oerr_d   = 1'b0;
            result_d = mul_step[DATA_W-1:0];
            carry_d  = |mul_step[2*DATA_W-1:DATA_W];
            zero_d   = (mul_step[DATA_W-1:0] == '0);
          end
        end
      end

      MAC_ADD: begin
        state_d  = IDLE;
        done_d   = 1'b1;
        oerr_d   = 1'b0;
        result_d = mac_sum[DATA_W-1:0];
        carry_d  = |mac_sum[2*DATA_W:DATA_W];
        zero_d   = (mac_sum[DATA_W-1:0] == '0);
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.result      = result_q;
  assign bus.carry       = carry_q;
  assign bus.zero        = zero_q;
  assign bus.done        = done_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.operand_err = oerr_q;

endmodule

// File: tb/tb_op_exec_unit.sv
// Self-checking bench for op_exec_unit: directed cases plus randomized ops
// compared against an arithmetic reference model.
module tb_op_exec_unit;
  localparam int DATA_W = 8;
  localparam int PC_W   = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  op_exec_unit_if #(.DATA_W(DATA_W), .PC_W(PC_W)) bus ();

  op_exec_unit #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Expected architectural outputs after the last completion
  int exp_res = 0;
  bit exp_cy  = 0;
  bit exp_z   = 0;
  bit exp_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: result, carry, acceptance and completion latency
  function automatic void ref_op(input int op, input int a, input int b, input int c,
                                 input bit va, input bit vb, input bit vc,
                                 output bit ok, output int res, output bit cy, output int lat);
    int n, p;
    bit need_b, need_c;
    need_b = (op != 5);
    need_c = (op == 9 || op == 10);
    ok  = (op <= 10) && va && (vb || !need_b) && (vc || !need_c);
    res = 0;
    cy  = 0;
    lat = 1;
    if (!ok) return;
    n = b % 8;
    case (op)
      0: begin p = a + b; res = p % 256; cy = (p > 255); end
      1: begin res = (a - b + 256) % 256; cy = (a < b); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = 255 - a;
      6: begin res = (a * (1 << n)) % 256; cy = (n != 0) && (((a >> (8 - n)) & 1) == 1); end
      7: begin res = a / (1 << n); cy = (n != 0) && (((a >> (n - 1)) & 1) == 1); end
      8: begin p = a * b; res = p % 256; cy = (p > 255); lat = 8; end
      9: begin p = a * b + c; res = p % 256; cy = (p > 255); lat = 9; end
      default: begin p = a + b + c; res = p % 256; cy = (p > 255); end
    endcase
  endfunction

  task automatic drive(input int op, input int a, input int b, input int c,
                       input bit va, input bit vb, input bit vc, input int pc);
    bus.opcode   = op[3:0];
    bus.r0       = a[7:0];
    bus.r1       = b[7:0];
    bus.r2       = c[7:0];
    bus.r0_valid = va;
    bus.r1_valid = vb;
    bus.r2_valid = vc;
    bus.prog_ctr = pc[PC_W-1:0];
  endtask

  // Issue one op, wait (bounded) for done, check latency and outputs
  task automatic run_op(input string tag, input int op, input int a, input int b, input int c,
                        input bit va, input bit vb, input bit vc, input int pc);
    bit ok, cy;
    int res, lat, seen;
    ref_op(op, a, b, c, va, vb, vc, ok, res, cy, lat);
    @(negedge clk);
    drive(op, a, b, c, va, vb, vc, pc);
    bus.op_en = 1'b1;
    @(posedge clk);
    #1;
    bus.op_en = 1'b0;
    check_val({tag, ".busy"}, 32'(bus.busy), 32'd1);
    seen = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) check_val({tag, ".busy_run"}, 32'(bus.busy), 32'd1);
      @(posedge clk);
      #1;
      if (bus.done) begin
        seen = k;
        break;
      end
    end
    if (ok) begin
      exp_res = res;
      exp_cy  = cy;
      exp_z   = (res == 0);
      exp_err = 0;
    end else begin
      exp_err = 1;
    end
    check_val({tag, ".latency"}, 32'(seen), 32'(lat));
    check_val({tag, ".busy_at_done"}, 32'(bus.busy), 32'd0);
    check_val({tag, ".result"}, 32'(bus.result), 32'(exp_res));
    check_val({tag, ".carry"}, 32'(bus.carry), 32'(exp_cy));
    check_val({tag, ".zero"}, 32'(bus.zero), 32'(exp_z));
    check_val({tag, ".operand_err"}, 32'(bus.operand_err), 32'(exp_err));
    $display("op %-10s opc=%0d r0=%0d r1=%0d r2=%0d v=%0d%0d%0d pc=%0d -> res=%0d c=%0d z=%0d err=%0d lat=%0d",
             tag, op, a, b, c, va, vb, vc, pc, bus.result, bus.carry, bus.zero, bus.operand_err, seen);
  endtask

  // Count done pulses over a number of cycles
  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) cnt++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
    exp_res = 0;
    exp_cy  = 0;
    exp_z   = 0;
    exp_err = 0;
  endtask

  initial begin
    int cnt, op, a, b, c;
    bit va, vb, vc;
    reset = 1'b1;
    bus.op_en = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_val("rst.result", 32'(bus.result), 32'd0);
    check_val("rst.flags", {29'd0, bus.carry, bus.zero, bus.operand_err}, 32'd0);
    check_val("rst.done_busy", {30'd0, bus.done, bus.busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // PC all ones is never accepted right after reset
    drive(0, 1, 1, 0, 1, 1, 0, 32'hFFF);
    bus.op_en = 1'b1;
    count_done(6, cnt);
    bus.op_en = 1'b0;
    check_val("pc_ones.done_count", 32'(cnt), 32'd0);
    $display("op pc_ones    dones=%0d", cnt);

    run_op("add",     0, 200, 100, 0,   1, 1, 0, 1);
    run_op("sub",     1, 5,   7,   0,   1, 1, 0, 2);
    run_op("shl",     6, 8'h81, 1, 0,   1, 1, 0, 3);
    run_op("mul",     8, 15,  17,  0,   1, 1, 0, 4);
    run_op("mul_zero", 8, 16, 16,  0,   1, 1, 0, 5);
    run_op("mac",     9, 3,   4,   250, 1, 1, 1, 6);
    run_op("err_vld", 0, 9,   9,   0,   1, 0, 0, 8);
    run_op("err_opc", 12, 1,  1,   1,   1, 1, 1, 9);
    run_op("shr",     7, 8'h81, 1, 0,   1, 1, 0, 10);
    run_op("shl0",    6, 8'h81, 0, 0,   1, 1, 0, 11);

    // op_en held five cycles on one PC: exactly one execution
    @(negedge clk);
    drive(0, 1, 2, 0, 1, 1, 0, 7);
    bus.op_en = 1'b1;
    count_done(5, cnt);
    @(negedge clk);
    bus.op_en = 1'b0;
    begin
      int more;
      count_done(3, more);
      cnt += more;
    end
    check_val("held_pc.done_count", 32'(cnt), 32'd1);
    check_val("held_pc.result", 32'(bus.result), 32'd3);
    $display("op held_pc   dones=%0d res=%0d", cnt, bus.result);

    // op_en during a busy MUL is ignored
    @(negedge clk);
    drive(8, 12, 11, 0, 1, 1, 0, 20);
    bus.op_en = 1'b1;
    @(negedge clk);
    drive(0, 1, 1, 0, 1, 1, 0, 21);
    repeat (3) @(negedge clk);
    bus.op_en = 1'b0;
    count_done(10, cnt);
    check_val("busy_ign.done_count", 32'(cnt), 32'd1);
    check_val("busy_ign.result", 32'(bus.result), 32'd132);
    check_val("busy_ign.carry", 32'(bus.carry), 32'd0);
    $display("op busy_ign  dones=%0d res=%0d", cnt, bus.result);
    exp_res = 132; exp_cy = 0; exp_z = 0; exp_err = 0;
    // PC 21 was never latched, so it is still issuable
    run_op("pc21", 1, 1, 1, 0, 1, 1, 0, 21);

    // Reset at T+4 of a MUL aborts it
    @(negedge clk);
    drive(8, 200, 200, 0, 1, 1, 0, 30);
    bus.op_en = 1'b1;
    @(posedge clk);
    #1;
    bus.op_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_val("mid_rst.busy", 32'(bus.busy), 32'd0);
    check_val("mid_rst.done", 32'(bus.done), 32'd0);
    check_val("mid_rst.result", 32'(bus.result), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_res = 0; exp_cy = 0; exp_z = 0; exp_err = 0;
    count_done(10, cnt);
    check_val("mid_rst.done_count", 32'(cnt), 32'd0);
    $display("op mid_rst   dones=%0d res=%0d", cnt, bus.result);
    run_op("same_pc", 8, 200, 200, 0, 1, 1, 0, 30);

    // Randomized ops against the reference model
    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 15);
      if ($urandom_range(0, 3) != 0) op = $urandom_range(0, 10);
      a  = $urandom_range(0, 255);
      b  = $urandom_range(0, 255);
      c  = $urandom_range(0, 255);
      va = ($urandom_range(0, 7) != 0);
      vb = ($urandom_range(0, 7) != 0);
      vc = ($urandom_range(0, 7) != 0);
      run_op($sformatf("rnd%0d", i), op, a, b, c, va, vb, vc, 100 + i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
